// File: rtl/fir_stream_pkg.sv
// Shared types and helpers for the FIR output-stream path.
package fir_stream_pkg;

   localparam int FIR_DATA_WIDTH = 32;

   typedef struct packed {
      logic                      tlast;
      logic [FIR_DATA_WIDTH-1:0] tdata;
   } fir_entry_t;

   // Occupancy from wrap-bit pointers; the mask keeps the modulo-2*DEPTH arithmetic
   function automatic int unsigned fill_level(input int unsigned wr,
                                              input int unsigned rd,
                                              input int unsigned ptr_w);
      int unsigned mask;
      mask = (32'd1 << ptr_w) - 32'd1;
      return (wr - rd) & mask;
   endfunction

endpackage

// File: rtl/fir_sm_fifo_mem.sv
// Entry storage for fir_sm_fifo: one synchronous write port, one asynchronous read port.
module fir_sm_fifo_mem
   import fir_stream_pkg::*;
#(
   parameter type entry_t = fir_entry_t,
   parameter int  DEPTH   = 16,
   parameter int  ADDR_W  = $clog2(DEPTH)
)(
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  entry_t            wdata,
   input  logic [ADDR_W-1:0] raddr,
   output entry_t            rdata
);

   entry_t mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[waddr] <= wdata;
      end
   end

   assign rdata = mem_q[raddr];

endmodule

// File: rtl/fir_sm_fifo.sv
// Elastic FWFT AXI-Stream buffer behind the FIR SM_* master port.
// Define FIR_SM_FIFO_STATS_EN to add the beat_cnt/frame_cnt debug counters.
module fir_sm_fifo
   import fir_stream_pkg::*;
#(
   parameter  int DATA_WIDTH = FIR_DATA_WIDTH,
   parameter  int DEPTH      = 16,
   localparam int ADDR_W     = $clog2(DEPTH)
)(
   input  logic                  ACLK,
   input  logic                  ARESET,
   input  logic                  S_tvalid,
   input  logic [DATA_WIDTH-1:0] S_tdata,
   input  logic                  S_tlast,
   output logic                  S_tready,
   output logic                  M_tvalid,
   output logic [DATA_WIDTH-1:0] M_tdata,
   output logic                  M_tlast,
   input  logic                  M_tready,
   output logic [ADDR_W:0]       level
`ifdef FIR_SM_FIFO_STATS_EN
   ,
   output logic [15:0]           beat_cnt,
   output logic [15:0]           frame_cnt
`endif
);

   localparam int PTR_W = ADDR_W + 1;

   typedef struct packed {
      logic                  tlast;
      logic [DATA_WIDTH-1:0] tdata;
   } entry_t;

   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   logic [PTR_W-1:0] wr_nxt, rd_nxt, lvl_nxt;
   logic             push, pop;
   entry_t           wr_entry, rd_entry, head_nxt;

   assign push     = S_tvalid & S_tready;
   assign pop      = M_tvalid & M_tready;
   assign wr_nxt   = wr_ptr + PTR_W'(push);
   assign rd_nxt   = rd_ptr + PTR_W'(pop);
   assign lvl_nxt  = PTR_W'(fill_level(32'(wr_nxt), 32'(rd_nxt), PTR_W));
   assign level    = PTR_W'(fill_level(32'(wr_ptr), 32'(rd_ptr), PTR_W));
   assign wr_entry = '{tlast: S_tlast, tdata: S_tdata};

   fir_sm_fifo_mem #(
      .entry_t (entry_t),
      .DEPTH   (DEPTH),
      .ADDR_W  (ADDR_W)
   ) u_mem (
      .clk   (ACLK),
      .we    (push),
      .waddr (wr_ptr[ADDR_W-1:0]),
      .wdata (wr_entry),
      .raddr (rd_nxt[ADDR_W-1:0]),
      .rdata (rd_entry)
   );

   // The post-edge head is the word being written right now when it lands in an empty slot
   assign head_nxt = (rd_nxt == wr_ptr) ? wr_entry : rd_entry;

   always_ff @(posedge ACLK or negedge ARESET) begin
      if (!ARESET) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         S_tready <= 1'b0;
         M_tvalid <= 1'b0;
         M_tdata  <= '0;
         M_tlast  <= 1'b0;
      end else begin
         wr_ptr   <= wr_nxt;
         rd_ptr   <= rd_nxt;
         S_tready <= (lvl_nxt < PTR_W'(DEPTH));
         M_tvalid <= (lvl_nxt != '0);
         if (lvl_nxt != '0) begin
            M_tdata <= head_nxt.tdata;
            M_tlast <= head_nxt.tlast;
         end
      end
   end

`ifdef FIR_SM_FIFO_STATS_EN
   always_ff @(posedge ACLK or negedge ARESET) begin
      if (!ARESET) begin
         beat_cnt  <= '0;
         frame_cnt <= '0;
      end else if (pop) begin
         beat_cnt <= M_tlast ? 16'd0 : beat_cnt + 16'd1;
         if (M_tlast && (frame_cnt != 16'hFFFF)) begin
            frame_cnt <= frame_cnt + 16'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_fir_sm_fifo.sv
// Scoreboard bench for fir_sm_fifo: accepted beats queue their expected output, a monitor checks pops.
module tb_fir_sm_fifo;

   localparam int DW    = 32;
   localparam int DEPTH = 16;

   logic          ACLK     = 1'b0;
   logic          ARESET   = 1'b1;
   logic          S_tvalid = 1'b0;
   logic [DW-1:0] S_tdata  = '0;
   logic          S_tlast  = 1'b0;
   logic          S_tready;
   logic          M_tvalid;
   logic [DW-1:0] M_tdata;
   logic          M_tlast;
   logic          M_tready = 1'b0;
   logic [4:0]    level;
`ifdef FIR_SM_FIFO_STATS_EN
   logic [15:0]   beat_cnt;
   logic [15:0]   frame_cnt;
`endif

   int          checks    = 0;
   int          failures  = 0;
   int          popped    = 0;
   int          tlast_seen = 0;
   bit          done      = 1'b0;
   logic [32:0] exp_q [$];
   logic [32:0] exp_e;

   fir_sm_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
      .ACLK     (ACLK),
      .ARESET   (ARESET),
      .S_tvalid (S_tvalid),
      .S_tdata  (S_tdata),
      .S_tlast  (S_tlast),
      .S_tready (S_tready),
      .M_tvalid (M_tvalid),
      .M_tdata  (M_tdata),
      .M_tlast  (M_tlast),
      .M_tready (M_tready),
      .level    (level)
`ifdef FIR_SM_FIFO_STATS_EN
      ,
      .beat_cnt (beat_cnt),
      .frame_cnt(frame_cnt)
`endif
   );

   always #5 ACLK = ~ACLK;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Monitor: every popped beat must be the oldest accepted beat
   always @(negedge ACLK) begin
      if (ARESET && M_tvalid && M_tready) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL pop_unexpected actual=%0h required=none", {M_tlast, M_tdata});
         end else begin
            exp_e = exp_q.pop_front();
            check("pop_beat", {31'd0, M_tlast, M_tdata}, {31'd0, exp_e});
            popped++;
            if (M_tlast) tlast_seen++;
         end
      end
   end

   always @(negedge ACLK) begin
      if (ARESET) check("level_bound", {63'd0, (level <= 5'd16)}, 64'd1);
   end

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge ACLK);
         #1;
      end
   endtask

   task automatic send(input logic [DW-1:0] d, input logic l);
      bit ok;
      ok = 1'b0;
      S_tvalid = 1'b1;
      S_tdata  = d;
      S_tlast  = l;
      for (int i = 0; i < 500 && !ok; i++) begin
         @(negedge ACLK);
         if (S_tready) begin
            exp_q.push_back({l, d});
            ok = 1'b1;
         end
         @(posedge ACLK);
         #1;
      end
      S_tvalid = 1'b0;
      S_tlast  = 1'b0;
      if (!ok) begin
         checks++;
         failures++;
         $display("FAIL send_timeout actual=not_accepted required=accepted data=%0h", d);
      end
   endtask

   task automatic drain();
      M_tready = 1'b1;
      for (int i = 0; i < 2000; i++) begin
         @(negedge ACLK);
         if (level == 5'd0 && !M_tvalid) break;
      end
      check("drain_queue_empty", 64'(exp_q.size()), 64'd0);
      check("drain_level", {59'd0, level}, 64'd0);
      @(posedge ACLK);
      #1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int p0;

      // Reset hold
      #2 ARESET = 1'b0;
      #10;
      check("rst_s_tready", {63'd0, S_tready}, 64'd0);
      check("rst_m_tvalid", {63'd0, M_tvalid}, 64'd0);
      check("rst_m_tdata",  {32'd0, M_tdata},  64'd0);
      check("rst_m_tlast",  {63'd0, M_tlast},  64'd0);
      check("rst_level",    {59'd0, level},    64'd0);
      @(posedge ACLK);
      #1 ARESET = 1'b1;
      @(negedge ACLK);
      check("release_pre_edge_s_tready", {63'd0, S_tready}, 64'd0);
      @(posedge ACLK);
      #1;
      check("release_s_tready", {63'd0, S_tready}, 64'd1);
      check("release_level",    {59'd0, level},    64'd0);

      // Single word, held while the consumer stalls
      M_tready = 1'b0;
      send(32'h5, 1'b0);
      check("single_m_tvalid", {63'd0, M_tvalid}, 64'd1);
      check("single_m_tdata",  {32'd0, M_tdata},  64'd5);
      check("single_level",    {59'd0, level},    64'd1);
      for (int i = 0; i < 5; i++) begin
         @(negedge ACLK);
         check("hold_m_tdata",  {32'd0, M_tdata},  64'd5);
         check("hold_m_tvalid", {63'd0, M_tvalid}, 64'd1);
      end
      drain();
      check("empty_hold_m_tdata", {32'd0, M_tdata}, 64'd5);

      // Fill to DEPTH, refuse the extra beat, single pop frees a slot
      M_tready = 1'b0;
      for (int i = 1; i <= DEPTH; i++) send(32'(i), 1'b0);
      check("full_level",    {59'd0, level},    64'd16);
      check("full_s_tready", {63'd0, S_tready}, 64'd0);
      S_tvalid = 1'b1;
      S_tdata  = 32'd17;
      for (int i = 0; i < 3; i++) begin
         @(negedge ACLK);
         check("full_no_accept", {63'd0, S_tready}, 64'd0);
      end
      S_tvalid = 1'b0;
      check("full_level_after_extra", {59'd0, level}, 64'd16);
      p0 = popped;
      @(posedge ACLK);
      #1 M_tready = 1'b1;
      @(posedge ACLK);
      #1 M_tready = 1'b0;
      check("one_pop_count",   64'(popped - p0), 64'd1);
      check("pop_s_tready",    {63'd0, S_tready}, 64'd1);
      check("pop_level",       {59'd0, level},    64'd15);
      check("pop_next_head",   {32'd0, M_tdata},  64'd2);
      drain();

      // Continuous streaming 1..40
      M_tready = 1'b1;
      for (int i = 1; i <= 40; i++) send(32'(i), 1'b0);
      drain();

      // 600-beat frame, random gaps and random consumer stalls
      done = 1'b0;
      fork
         begin
            for (int i = 1; i <= 600; i++) begin
               send($urandom, (i == 600));
               if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
            end
            done = 1'b1;
         end
         begin
            while (!done) begin
               M_tready = ($urandom_range(0, 3) != 0);
               @(posedge ACLK);
               #1;
            end
         end
      join
      drain();
      check("frame_tlast_count", 64'(tlast_seen), 64'd1);
`ifdef FIR_SM_FIFO_STATS_EN
      check("stats_frame_cnt", {48'd0, frame_cnt}, 64'd1);
      check("stats_beat_cnt",  {48'd0, beat_cnt},  64'd0);
`endif

      // Reset while level = 7
      M_tready = 1'b0;
      for (int i = 0; i < 7; i++) send(32'h100 + 32'(i), 1'b0);
      check("pre_reset_level", {59'd0, level}, 64'd7);
      @(posedge ACLK);
      #2 ARESET = 1'b0;
      #1;
      check("midrst_m_tvalid", {63'd0, M_tvalid}, 64'd0);
      check("midrst_level",    {59'd0, level},    64'd0);
      check("midrst_s_tready", {63'd0, S_tready}, 64'd0);
      check("midrst_m_tdata",  {32'd0, M_tdata},  64'd0);
      exp_q.delete();
      @(posedge ACLK);
      #1 ARESET = 1'b1;
      @(posedge ACLK);
      #1;
      p0 = popped;
      M_tready = 1'b1;
      send(32'hA5, 1'b0);
      drain();
      check("post_reset_pop_count", 64'(popped - p0), 64'd1);

      check("end_queue_empty", 64'(exp_q.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
